// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multiport register file.
// Optional feature macro used by this slice: REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_t;

    localparam int RF_WIDTH  = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DEPTH  = 32;
    localparam int RF_NUM_RD = 2;

    // Width of the scrub counter; a single-entry file still needs one bit.
    function automatic int rf_cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: masks out-of-range and hardwired-zero
// addresses, forces zero while the array is being scrubbed and, when
// REGFILE_BYPASS_EN is defined, forwards same-cycle write data.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ZERO_REG = 1
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] ra,
    input  logic [WIDTH-1:0]  entry,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    output logic [WIDTH-1:0]  rd
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic in_range;
    logic is_zero;

    assign in_range = ({1'b0, ra} < DEPTH_LIM);
    assign is_zero  = (ZERO_REG != 0) && (ra == '0);

`ifndef REGFILE_BYPASS_EN
    // Write-side inputs only matter when forwarding is built in.
    logic unused_bypass;
    assign unused_bypass = ^{wr_valid, wa, wd};
`endif

    // Select stored value, forwarded data or zero for this port.
    always_comb begin
        rd = '0;
        if (ready && in_range && !is_zero) begin
            rd = entry;
`ifdef REGFILE_BYPASS_EN
            // wr_valid already excludes discarded writes, so forwarding
            // can never leak data for entry 0 or an unimplemented address.
            if (wr_valid && (ra == wa)) begin
                rd = wd;
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NUM_RD asynchronous read ports, one
// synchronous write port, optional hardwired-zero entry 0 and a scrub
// engine that zeroes the array after reset or on clr_req. The storage
// itself has no reset; the scrub provides the known state.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding).
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [WIDTH-1:0]         wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*WIDTH-1:0]  rd,
    input  logic                     clr_req,
    output logic                     ready
);

    localparam int              CW        = rf_cnt_w(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [CW-1:0]   LAST_IDX  = CW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    rf_state_t     state;
    logic [CW-1:0] clr_idx;
    logic          wr_ok;
    logic [CW-1:0] wa_idx;

    assign ready  = (state == RF_IDLE);
    assign wa_idx = wa[CW-1:0];
    assign wr_ok  = we && ready
                    && ({1'b0, wa} < DEPTH_LIM)
                    && !((ZERO_REG != 0) && (wa == '0));

    // Scrub sequencer: walk clr_idx through every entry, then idle until
    // a clear request; requests during a scrub are ignored.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state   <= RF_IDLE;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + CW'(1);
                    end
                end
                RF_IDLE: begin
                    if (clr_req) begin
                        state   <= RF_CLEAR;
                        clr_idx <= '0;
                    end
                end
                default: begin
                    state   <= RF_CLEAR;
                    clr_idx <= '0;
                end
            endcase
        end
    end

    // Storage update: scrub writes own the array while clearing.
    always_ff @(posedge clk) begin
        if (state == RF_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok) begin
            mem[wa_idx] <= wd;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        logic [CW-1:0]     idx_k;

        assign ra_k  = ra[k*ADDR_W +: ADDR_W];
        // Keep the array index legal; the port masks the value anyway.
        assign idx_k = ({1'b0, ra_k} < DEPTH_LIM) ? ra_k[CW-1:0] : '0;

        regfile_read_port #(
            .WIDTH    (WIDTH),
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .ready    (ready),
            .ra       (ra_k),
            .entry    (mem[idx_k]),
            .wr_valid (wr_ok),
            .wa       (wa),
            .wd       (wd),
            .rd       (rd[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: a default instance (32 entries, 2 ports,
// zero register) and a 24-entry, 3-port instance without zero register,
// both checked every cycle against an abstract array/countdown model.
module tb_regfile_multiport;

    logic        clk;
    logic        areset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        clr_req;
    logic [4:0]  a0 [2];
    logic [4:0]  a1 [3];
    logic [9:0]  ra0;
    logic [14:0] ra1;
    logic [63:0] rd0;
    logic [95:0] rd1;
    logic        ready0;
    logic        ready1;

    int checks = 0;
    int errors = 0;
    int n;

    // Model: remaining scrub edges per instance and the stored contents.
    int          left [2];
    logic [31:0] mm   [2][32];

    assign ra0 = {a0[1], a0[0]};
    assign ra1 = {a1[2], a1[1], a1[0]};

    regfile_multiport dut0 (
        .clk     (clk),
        .areset  (areset),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .ra      (ra0),
        .rd      (rd0),
        .clr_req (clr_req),
        .ready   (ready0)
    );

    regfile_multiport #(
        .WIDTH    (32),
        .ADDR_W   (5),
        .DEPTH    (24),
        .NUM_RD   (3),
        .ZERO_REG (0)
    ) dut1 (
        .clk     (clk),
        .areset  (areset),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .ra      (ra1),
        .rd      (rd1),
        .clr_req (clr_req),
        .ready   (ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int depth_of(int d);
        return (d == 0) ? 32 : 24;
    endfunction

    function automatic bit zero_of(int d);
        return (d == 0);
    endfunction

    function automatic bit wr_ok(int d);
        return we && (left[d] == 0) && (int'(wa) < depth_of(d))
               && !(zero_of(d) && (wa == 5'd0));
    endfunction

    function automatic logic [31:0] exp_rd(int d, logic [4:0] a);
        if (left[d] != 0) return 32'h0;
        if (int'(a) >= depth_of(d)) return 32'h0;
        if (zero_of(d) && (a == 5'd0)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr_ok(d) && (a == wa)) return wd;
`endif
        return mm[d][a];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ready0", {31'b0, ready0}, {31'b0, left[0] == 0});
        chk("ready1", {31'b0, ready1}, {31'b0, left[1] == 0});
        for (int k = 0; k < 2; k++)
            chk($sformatf("rd0_p%0d_a%0d", k, a0[k]), rd0[k*32 +: 32], exp_rd(0, a0[k]));
        for (int k = 0; k < 3; k++)
            chk($sformatf("rd1_p%0d_a%0d", k, a1[k]), rd1[k*32 +: 32], exp_rd(1, a1[k]));
    endtask

    task automatic model_edge();
        bit ok;
        for (int d = 0; d < 2; d++) begin
            if (!areset) begin
                left[d] = depth_of(d);
            end else if (left[d] > 0) begin
                left[d]--;
                if (left[d] == 0)
                    for (int i = 0; i < 32; i++) mm[d][i] = 32'h0;
            end else begin
                ok = wr_ok(d);
                if (ok) mm[d][wa] = wd;
                if (clr_req) left[d] = depth_of(d);
            end
        end
    endtask

    // Inputs are set after a falling edge; outputs are checked 1 time unit
    // later, then the model advances on the rising edge.
    task automatic tick();
        if (!areset) begin
            left[0] = 32;
            left[1] = 24;
        end
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        areset  = 1'b0;
        we      = 1'b0;
        wa      = '0;
        wd      = '0;
        clr_req = 1'b0;
        for (int k = 0; k < 2; k++) a0[k] = '0;
        for (int k = 0; k < 3; k++) a1[k] = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) mm[d][i] = 32'h0;
        left[0] = 32;
        left[1] = 24;

        // Reset and initial scrub
        @(negedge clk);
        tick();
        tick();
        areset = 1'b1;
        a0[0] = 5'd7;  a0[1] = 5'd31;
        a1[0] = 5'd7;  a1[1] = 5'd31; a1[2] = 5'd23;
        n = 0;
        while (!ready0 && n < 100) begin
            tick();
            n++;
        end
        chk("rst_clr_len", n, 32);
        tick();

        // Write with same-cycle read, then read back
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        a0[0] = 5'd5; a0[1] = 5'd5; a1[0] = 5'd5;
        tick();
        we = 1'b0;
        tick();

        // Entry 0: hardwired zero on dut0, ordinary on dut1
        we = 1'b1; wa = 5'd0; wd = 32'h00001234;
        a0[0] = 5'd0; a1[0] = 5'd0;
        tick();
        we = 1'b0;
        tick();

        // Requested clear with a dropped write and a repeated request
        we = 1'b1; wa = 5'd5; wd = 32'h0BADF00D;
        tick();
        we = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        a0[0] = 5'd5; a0[1] = 5'd9; a1[0] = 5'd5; a1[1] = 5'd9;
        n = 0;
        while (!ready0 && n < 100) begin
            we = (n == 0); wa = 5'd9; wd = 32'h000000AA;
            clr_req = (n == 10);
            tick();
            n++;
        end
        we = 1'b0;
        clr_req = 1'b0;
        chk("req_clr_len", n, 32);
        tick();

        // Reset while clr_idx is 10
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        areset = 1'b0;
        tick();
        tick();
        areset = 1'b1;
        n = 0;
        while (!ready0 && n < 100) begin
            tick();
            n++;
        end
        chk("midclr_rst_len", n, 32);

        // Out-of-range and last-entry writes on the 24-entry instance
        we = 1'b1; wa = 5'd30; wd = 32'h00000055;
        a1[2] = 5'd30;
        tick();
        we = 1'b0;
        tick();
        we = 1'b1; wa = 5'd23; wd = 32'h00000077;
        a1[0] = 5'd23; a1[1] = 5'd23; a1[2] = 5'd23;
        tick();
        we = 1'b0;
        tick();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            areset  = ($urandom_range(0, 199) != 0);
            clr_req = ($urandom_range(0, 59) == 0);
            we      = $urandom_range(0, 1);
            wa      = 5'($urandom_range(0, 31));
            wd      = $urandom;
            for (int k = 0; k < 2; k++) a0[k] = 5'($urandom_range(0, 31));
            for (int k = 0; k < 3; k++) a1[k] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) begin
                a0[0] = wa;
                a1[1] = wa;
            end
            tick();
        end
        areset  = 1'b1;
        clr_req = 1'b0;
        we      = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the core's integer register file. Provides a configurable number of asynchronous read ports, one synchronous write port, an optional hardwired-zero entry 0, and a self-clearing scrub engine. The scrub engine zeroes the whole array after reset or on request, so the storage array itself needs no reset fanout. It sits in the decode stage of the RISC-V pipeline and feeds the operand muxes.

## Interface
- WIDTH, 32, data width of each entry
- ADDR_W, 5, address width of every port
- DEPTH, 32, number of implemented entries (DEPTH ≤ 2^ADDR_W)
- NUM_RD, 2, number of read ports (≥1)
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes
- clk  input  1  rising-edge clock
- areset  input  1  asynchronous, active-low reset
- we  input  1  write enable
- wa  input  ADDR_W  write address
- wd  input  WIDTH  write data
- ra  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd  output  NUM_RD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH]
- clr_req  input  1  single-cycle pulse requesting a full clear
- ready  output  1  array valid; low while clearing

## Operation
- FSM has two states: CLEAR and IDLE. A 0..DEPTH-1 counter `clr_idx` runs in CLEAR.
- areset low: state goes to CLEAR, `clr_idx` goes to 0, `ready` goes to 0. Array contents are not touched by reset.
- CLEAR:
  - Each rising edge writes 0 to entry `clr_idx` and increments `clr_idx`.
  - On the edge that clears entry DEPTH-1, the FSM goes to IDLE and `ready` becomes 1.
  - User writes are dropped.
  - `clr_req` is ignored and does not restart the count.
  - All `rd` ports are forced to 0.
- IDLE:
  - `ready` = 1.
  - If `we` is high, the rising edge writes `wd` to entry `wa`.
  - `clr_req` high on an edge moves the FSM to CLEAR with `clr_idx` = 0 and drops `ready` to 0 on that same edge. A write in that same cycle is still performed, but the clear overwrites it later.
- Write discard rules:
  - `wa` ≥ DEPTH: write dropped.
  - ZERO_REG=1 and `wa`=0: write dropped.
- Read rules, independent per port, combinational:
  - `ra_k` ≥ DEPTH returns 0.
  - ZERO_REG=1 and `ra_k`=0 returns 0.
  - Otherwise returns the entry value, modified by the bypass rule in Configuration.
- Several read ports may address the same entry; each returns the same value.

## Timing
- Reset values: `ready`=0, all `rd`=0, state=CLEAR, `clr_idx`=0.
- Clear duration: `ready` rises exactly DEPTH rising edges after areset deasserts, or after the edge that sampled `clr_req`.
- Write latency: 1 edge. Data written on edge N is visible on reads from edge N onward.
- Read latency: 0 cycles (combinational from `ra`).
- areset asserted mid-clear: the count restarts from 0, and a full DEPTH cycles are required again after release.
- Applying `clr_req` and areset together: reset wins.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-through bypass is enabled.
  - Condition: `ready`=1, `we`=1, the write is not discarded, and `ra_k`==`wa`.
  - Result: `rd_k` returns `wd` in the same cycle, before the edge.
- Undefined: `rd_k` returns the stored value. The new data appears only after the write edge.
- The discard rules (zero register, out-of-range address) apply in both builds, so a bypass never exposes a nonzero value for entry 0 or for an out-of-range address.

## Structure
- Package `regfile_pkg` holds:
  - typedef `rf_state_t` {RF_CLEAR, RF_IDLE}
  - default constants `RF_WIDTH`, `RF_ADDR_W`, `RF_DEPTH`, `RF_NUM_RD`
  - localparam function for the counter width, $clog2(DEPTH)
- Sub-module `regfile_read_port`, instantiated NUM_RD times through generate. It implements the out-of-range/zero masking, the optional bypass mux and the CLEAR forcing for one port.
- The top level holds the array, the write logic, the FSM and the counter.

## Test plan
- Reset release with defaults: `ready`=0 for 32 edges, then 1. Reading ra0=7 and ra1=31 returns 0 both during and after the clear.
- Write 0xDEADBEEF to entry 5 (`we`=1): in the same cycle ra0=5 returns 0xDEADBEEF with BYPASS_EN and 0 without it. After the edge, both builds return 0xDEADBEEF.
- Write 0x00001234 to entry 0 with ZERO_REG=1: reading entry 0 returns 0. With ZERO_REG=0, it returns 0x00001234 after the edge.
- Fill entry 5, then pulse `clr_req`:
  - `ready` goes low for 32 edges.
  - A write of 0xAA to entry 9 during the clear is dropped.
  - Afterwards entries 5 and 9 read 0.
  - A second `clr_req` mid-clear does not extend the clear beyond 32 edges.
- areset pulse while `clr_idx`=10: `ready` stays 0, and after release a full 32 edges pass before `ready`=1.
- NUM_RD=3, DEPTH=24, ADDR_W=5:
  - A write of 0x55 to entry 30 is dropped.
  - ra2=30 returns 0.
  - A write of 0x77 to entry 23 is visible on all three ports.
